// File: rtl/z80_busrq_arbiter_if.sv
// Bus-request handshake bundle shared by the arbiter, the Z80 core and the external masters.
// The master modport is the arbiter side; the slave modport is the system/requester side.
interface z80_busrq_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0] req;
   logic            nBUSACK;
   logic            nBUSRQ;
   logic [NREQ-1:0] gnt;
   logic            bus_oe;
   logic [2:0]      owner_id;
   logic            ack_timeout;

   modport master (
      input  req,
      input  nBUSACK,
      output nBUSRQ,
      output gnt,
      output bus_oe,
      output owner_id,
      output ack_timeout
   );

   modport slave (
      output req,
      output nBUSACK,
      input  nBUSRQ,
      input  gnt,
      input  bus_oe,
      input  owner_id,
      input  ack_timeout
   );
endinterface

// File: rtl/z80_busrq_arbiter.sv
// Round-robin arbiter that borrows the Z80 bus via nBUSRQ/nBUSACK and hands it to one
// external master at a time, chaining up to MAX_CHAIN grants per CPU bus release.
module z80_busrq_arbiter #(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned MAX_CHAIN   = 4,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input logic                 CLK,
   input logic                 RESET,
   z80_busrq_arbiter_if.master bus
);
   localparam int unsigned CW = $clog2(MAX_CHAIN + 1);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StReqWait, StGrant, StSwitch, StRelease} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_ack_meta, r_ack_s;
   logic            r_nbusrq, w_nbusrq_nxt;
   logic [NREQ-1:0] r_gnt, w_gnt_nxt;
   logic            r_bus_oe;
   logic [2:0]      r_owner_id, w_owner_nxt;
   logic [CW-1:0]   r_chain_cnt, w_chain_nxt;
   logic [TW-1:0]   r_to_cnt, w_to_cnt_nxt;
   logic            r_ack_timeout, w_timeout_nxt;
   logic            w_req_any, w_own_req;
   logic [2:0]      w_pick;

   // First requester strictly after 'last', wrapping mod NREQ.
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] last);
      logic [2:0]  res;
      int unsigned idx;
      res = last;
      for (int i = int'(NREQ); i > 0; i--) begin
         idx = (32'(last) + 32'(i)) % NREQ;
         if (|(req & (NREQ'(1) << idx))) res = 3'(idx);
      end
      return res;
   endfunction

   assign w_req_any = |bus.req;
   assign w_own_req = |(bus.req & r_gnt);
   assign w_pick    = rr_pick(bus.req, r_owner_id);

   always_comb begin
      w_state_nxt   = r_state;
      w_nbusrq_nxt  = r_nbusrq;
      w_gnt_nxt     = r_gnt;
      w_owner_nxt   = r_owner_id;
      w_chain_nxt   = r_chain_cnt;
      w_to_cnt_nxt  = '0;
      w_timeout_nxt = r_ack_timeout;
      unique case (r_state)
         StIdle: begin
            if (w_req_any) begin
               w_state_nxt  = StReqWait;
               w_nbusrq_nxt = 1'b0;
            end
         end
         StReqWait: begin
            w_to_cnt_nxt = (r_to_cnt == TW'(ACK_TIMEOUT)) ? r_to_cnt : r_to_cnt + TW'(1);
            if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) w_timeout_nxt = 1'b1;
            if (!w_req_any) begin
               w_state_nxt  = StRelease;
               w_nbusrq_nxt = 1'b1;
            end else if (!r_ack_s) begin
               w_state_nxt = StGrant;
               w_gnt_nxt   = NREQ'(1) << w_pick;
               w_owner_nxt = w_pick;
               w_chain_nxt = CW'(1);
            end
         end
         StGrant: begin
            // No preemption: the owner keeps the bus until it drops its own request.
            if (!w_own_req) begin
               w_gnt_nxt = '0;
               if (w_req_any && (r_chain_cnt < CW'(MAX_CHAIN))) begin
                  w_state_nxt = StSwitch;
               end else begin
                  w_state_nxt  = StRelease;
                  w_nbusrq_nxt = 1'b1;
               end
            end
         end
         StSwitch: begin
            if (w_req_any) begin
               w_state_nxt = StGrant;
               w_gnt_nxt   = NREQ'(1) << w_pick;
               w_owner_nxt = w_pick;
               w_chain_nxt = r_chain_cnt + CW'(1);
            end else begin
               w_state_nxt  = StRelease;
               w_nbusrq_nxt = 1'b1;
            end
         end
         StRelease: begin
            if (r_ack_s) begin
               w_state_nxt = StIdle;
               w_chain_nxt = '0;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= StIdle;
         r_ack_meta    <= 1'b1;
         r_ack_s       <= 1'b1;
         r_nbusrq      <= 1'b1;
         r_gnt         <= '0;
         r_bus_oe      <= 1'b0;
         r_owner_id    <= 3'(NREQ - 1);
         r_chain_cnt   <= '0;
         r_to_cnt      <= '0;
         r_ack_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ack_meta    <= bus.nBUSACK;
         r_ack_s       <= r_ack_meta;
         r_nbusrq      <= w_nbusrq_nxt;
         r_gnt         <= w_gnt_nxt;
         r_bus_oe      <= |w_gnt_nxt;
         r_owner_id    <= w_owner_nxt;
         r_chain_cnt   <= w_chain_nxt;
         r_to_cnt      <= w_to_cnt_nxt;
         r_ack_timeout <= w_timeout_nxt;
      end
   end

   assign bus.nBUSRQ      = r_nbusrq;
   assign bus.gnt         = r_gnt;
   assign bus.bus_oe      = r_bus_oe;
   assign bus.owner_id    = r_owner_id;
   assign bus.ack_timeout = r_ack_timeout;
endmodule

// File: tb/tb_z80_busrq_arbiter.sv
// Bench for z80_busrq_arbiter: directed scenarios, a CPU bus-ack model, and an
// episode-level reference model compared against the outputs on every falling edge.
module tb_z80_busrq_arbiter;
   localparam int unsigned NREQ      = 2;
   localparam int unsigned MAX_CHAIN = 4;
   localparam int unsigned ACK_TO    = 16;
   localparam int unsigned ACK_DLY   = 5;

   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_OWN  = 2;
   localparam int PH_GAP  = 3;
   localparam int PH_RET  = 4;

   logic CLK;
   logic RESET;
   bit   cpu_en;
   int   n_checks;
   int   n_fail;

   z80_busrq_arbiter_if #(.NREQ(NREQ)) bus ();

   z80_busrq_arbiter #(
      .NREQ        (NREQ),
      .MAX_CHAIN   (MAX_CHAIN),
      .ACK_TIMEOUT (ACK_TO)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (one bus-borrowing episode at a time) ----------------
   int              m_phase, m_owner, m_chain, m_wait;
   logic            m_rq_n, m_to, m_s1, m_s2;
   logic [NREQ-1:0] m_gnt;

   function automatic int next_owner(input logic [NREQ-1:0] r, input int last);
      int c;
      for (int d = 1; d <= int'(NREQ); d++) begin
         c = (last + d) % int'(NREQ);
         if (((r >> c) & NREQ'(1)) != '0) return c;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_phase = PH_IDLE;
      m_owner = int'(NREQ) - 1;
      m_chain = 0;
      m_wait  = 0;
      m_rq_n  = 1'b1;
      m_to    = 1'b0;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_gnt   = '0;
   endtask

   task automatic m_give(input int who);
      m_owner = who;
      m_gnt   = NREQ'(1) << who;
      m_phase = PH_OWN;
   endtask

   task automatic m_step();
      logic            cpu_gave;
      logic [NREQ-1:0] r;
      cpu_gave = ~m_s2;
      r        = bus.req;
      case (m_phase)
         PH_IDLE: if (r != '0) begin
            m_phase = PH_WAIT;
            m_rq_n  = 1'b0;
            m_wait  = 0;
         end
         PH_WAIT: begin
            m_wait++;
            if (m_wait == int'(ACK_TO)) m_to = 1'b1;
            if (r == '0) begin
               m_phase = PH_RET;
               m_rq_n  = 1'b1;
            end else if (cpu_gave) begin
               m_give(next_owner(r, m_owner));
               m_chain = 1;
            end
         end
         PH_OWN: if (((r >> m_owner) & NREQ'(1)) == '0) begin
            m_gnt = '0;
            if (r != '0 && m_chain < int'(MAX_CHAIN)) m_phase = PH_GAP;
            else begin
               m_phase = PH_RET;
               m_rq_n  = 1'b1;
            end
         end
         PH_GAP: if (r == '0) begin
            m_phase = PH_RET;
            m_rq_n  = 1'b1;
         end else begin
            m_give(next_owner(r, m_owner));
            m_chain++;
         end
         PH_RET: if (!cpu_gave) begin
            m_phase = PH_IDLE;
            m_chain = 0;
         end
         default: m_phase = PH_IDLE;
      endcase
      m_s2 = m_s1;
      m_s1 = bus.nBUSACK;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge CLK or posedge RESET);
         if (RESET) m_reset();
         else m_step();
      end
   end

   // ---------------- compare process + CPU bus-ack model ----------------
   initial begin
      int cnt;
      cnt         = 0;
      bus.nBUSACK = 1'b1;
      forever begin
         @(negedge CLK);
         check("nBUSRQ", 32'(bus.nBUSRQ), 32'(m_rq_n));
         check("gnt", 32'(bus.gnt), 32'(m_gnt));
         check("bus_oe", 32'(bus.bus_oe), 32'(|m_gnt));
         check("owner_id", 32'(bus.owner_id), 32'(m_owner));
         check("ack_timeout", 32'(bus.ack_timeout), 32'(m_to));
         check("inv_onehot", 32'($onehot0(bus.gnt)), 32'd1);
         check("inv_bus_oe", 32'(bus.bus_oe), 32'(|bus.gnt));
         if (bus.gnt != '0) check("inv_gnt_cpu_off", 32'({bus.nBUSRQ, bus.nBUSACK}), 32'd0);
         // CPU gives up the bus ACK_DLY cycles into a request, takes it back at once
         if (bus.nBUSRQ) begin
            cnt         = 0;
            bus.nBUSACK = 1'b1;
         end else begin
            cnt++;
            if (cpu_en && cnt >= int'(ACK_DLY)) bus.nBUSACK = 1'b0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET   = 1'b1;
      bus.req = '0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic wait_gnt(input int budget, output int who, output bit rq_high);
      who     = -1;
      rq_high = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (bus.gnt != '0) break;
         if (bus.nBUSRQ) rq_high = 1'b1;
         tick(1);
      end
      for (int i = 0; i < int'(NREQ); i++)
         if (bus.gnt == (NREQ'(1) << i)) who = i;
      if (who < 0) check("wait_gnt_expired", 32'(bus.gnt), 32'hFFFF_FFFF);
   endtask

   initial begin
      int who;
      bit rq_high;
      bit seen;
      n_checks = 0;
      n_fail   = 0;
      cpu_en   = 1'b1;

      // Single master
      do_reset();
      check("rst_nBUSRQ", 32'(bus.nBUSRQ), 32'd1);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_owner", 32'(bus.owner_id), 32'd1);
      bus.req = 2'b01;
      tick(1);  check("t1_nBUSRQ_c1", 32'(bus.nBUSRQ), 32'd0);
      tick(6);  check("t1_gnt_c7", 32'(bus.gnt), 32'd0);
      tick(1);  check("t1_gnt_c8", 32'(bus.gnt), 32'd1);
      check("t1_bus_oe_c8", 32'(bus.bus_oe), 32'd1);
      check("t1_owner_c8", 32'(bus.owner_id), 32'd0);
      tick(12); bus.req = 2'b00;
      tick(1);  check("t1_gnt_c21", 32'(bus.gnt), 32'd0);
      check("t1_nBUSRQ_c21", 32'(bus.nBUSRQ), 32'd1);
      tick(6);

      // Simultaneous requests: master 0 first, one-cycle turnaround, then master 1
      do_reset();
      bus.req = 2'b11;
      tick(8);  check("t2_gnt_c8", 32'(bus.gnt), 32'd1);
      tick(4);  bus.req = 2'b10;
      tick(1);  check("t2_gap_gnt", 32'(bus.gnt), 32'd0);
      check("t2_gap_nBUSRQ", 32'(bus.nBUSRQ), 32'd0);
      tick(1);  check("t2_gnt_m1", 32'(bus.gnt), 32'd2);
      check("t2_owner_m1", 32'(bus.owner_id), 32'd1);
      tick(2);  bus.req = 2'b00;
      tick(8);

      // Fairness and chain limit: 0,1,0,1 in one episode, then CPU gets the bus back
      do_reset();
      bus.req = 2'b11;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(40, who, rq_high);
         check("t3_owner_order", 32'(who), 32'(g % 2));
         if (g == 4) check("t3_cpu_regains_bus", 32'(rq_high), 32'd1);
         else if (g > 0) check("t3_chained", 32'(rq_high), 32'd0);
         if (who < 0) break;
         tick(2); bus.req = bus.req & ~(NREQ'(1) << who);
         tick(1); bus.req = bus.req | (NREQ'(1) << who);
      end
      bus.req = 2'b00;
      tick(10);

      // Request withdrawn before the CPU acknowledges
      do_reset();
      bus.req = 2'b01;
      tick(3);  bus.req = 2'b00;
      tick(1);  check("t4_nBUSRQ_c4", 32'(bus.nBUSRQ), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (bus.gnt != '0) seen = 1'b1;
         tick(1);
      end
      check("t4_no_gnt", 32'(seen), 32'd0);

      // CPU never acknowledges, then reset in the middle of a grant
      do_reset();
      cpu_en  = 1'b0;
      bus.req = 2'b01;
      tick(16); check("t5_to_c16", 32'(bus.ack_timeout), 32'd0);
      tick(1);  check("t5_to_c17", 32'(bus.ack_timeout), 32'd1);
      tick(13); check("t5_to_sticky", 32'(bus.ack_timeout), 32'd1);
      check("t5_no_gnt", 32'(bus.gnt), 32'd0);
      cpu_en = 1'b1;
      wait_gnt(20, who, rq_high);
      check("t5_late_gnt", 32'(who), 32'd0);
      tick(2);
      #3 RESET = 1'b1;
      #1;
      check("t6_rst_nBUSRQ", 32'(bus.nBUSRQ), 32'd1);
      check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
      check("t6_rst_bus_oe", 32'(bus.bus_oe), 32'd0);
      check("t6_rst_to", 32'(bus.ack_timeout), 32'd0);
      bus.req = 2'b00;
      @(posedge CLK);
      #1 RESET = 1'b0;
      bus.req = 2'b11;
      wait_gnt(30, who, rq_high);
      check("t6_restart_m0", 32'(who), 32'd0);
      bus.req = 2'b00;
      tick(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/z80_busrq_arbiter.md
Name: z80_busrq_arbiter

Overview:
Shares the Z80 system bus between the CPU core (z80_top_direct_n) and up to NREQ bus masters (DMA, video fetch, debug loader). It drives the CPU's nBUSRQ, synchronises nBUSACK, and grants the bus to one requester at a time, round-robin. Consecutive grants can be chained without returning the bus to the CPU, up to MAX_CHAIN. Sits beside the CPU in the top level; gnt/bus_oe select the master's drivers onto A/D/control.

Parameters:
NREQ, 2, number of external bus masters (1..8)
MAX_CHAIN, 4, max grants per nBUSRQ episode before the bus must return to the CPU
ACK_TIMEOUT, 1024, cycles waiting for nBUSACK before flagging ack_timeout

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
req  in  NREQ  per-master request; held high for the whole transfer, dropped when done
nBUSACK  in  1  from CPU, active low, asynchronous to arbiter logic
nBUSRQ  out  1  to CPU, active low, registered
gnt  out  NREQ  one-hot grant, registered
bus_oe  out  1  high while any gnt bit is high; enables master drivers
owner_id  out  3  index of current/last owner
ack_timeout  out  1  sticky flag: nBUSACK not seen within ACK_TIMEOUT cycles

Behaviour:
- Reset values: nBUSRQ=1, gnt=0, bus_oe=0, owner_id=NREQ-1 (first pick is master 0), ack_timeout=0, chain_cnt=0, state=IDLE, sync flops=1.
- nBUSACK passes through a 2-flop synchroniser -> ack_s (low = bus granted by CPU).
- States: IDLE, REQ_WAIT, GRANT, SWITCH, RELEASE.
- IDLE: nBUSRQ=1. If |req -> REQ_WAIT; nBUSRQ goes low on the same edge.
- REQ_WAIT: nBUSRQ=0, timeout counter runs.
  - ack_s==0 with |req -> GRANT. Owner = first set req bit searching upward from owner_id+1, wrapping mod NREQ. gnt and bus_oe go high on that edge. chain_cnt=1.
  - Total latency: 3 CLK edges after nBUSACK falls.
  - req==0 before ack -> RELEASE.
  - Counter reaching ACK_TIMEOUT sets ack_timeout (sticky until RESET). Waiting continues.
- GRANT: gnt one-hot at owner, bus_oe=1, nBUSRQ=0.
  - req[owner] stays high -> hold; no preemption.
  - req[owner] falls -> gnt=0 and bus_oe=0 on the next edge.
  - Then, if another req is set and chain_cnt<MAX_CHAIN -> SWITCH; otherwise -> RELEASE.
- SWITCH: exactly 1 cycle with gnt=0 (bus turnaround), nBUSRQ held 0. Picks the next owner round-robin from req sampled in this cycle. Then GRANT with chain_cnt+1.
  - If req==0 in SWITCH -> RELEASE.
- RELEASE: nBUSRQ=1, gnt=0. New requests are ignored. When ack_s==1 -> IDLE with chain_cnt=0, so at least one CPU cycle is guaranteed between episodes.
- owner_id updates only when a grant is issued.
- Simultaneous requests: round-robin order, never two gnt bits high.
- A requester dropping and re-raising req within one cycle is treated as released.
- RESET mid-grant forces all outputs to reset values immediately (asynchronous). Masters must tolerate gnt loss.
- Invariants (assert in bench):
  - gnt is one-hot or zero.
  - bus_oe == |gnt.
  - gnt!=0 implies nBUSRQ==0 and ack_s==0.

Test Plan:
- Single master: req[0]=1 at cycle 0 -> nBUSRQ=0 at cycle 1. CPU model drops nBUSACK at cycle 5 -> gnt=01, bus_oe=1 at cycle 8. req[0]=0 at cycle 20 -> gnt=00 at cycle 21, nBUSRQ=1 at cycle 21, IDLE after nBUSACK returns high + 2 cycles.
- Simultaneous req=11 from reset -> grant master 0 first. On its release: 1-cycle SWITCH gap (gnt=00), then gnt=10, all with nBUSRQ held low.
- Fairness: both masters request continuously with MAX_CHAIN=4 -> grants alternate 0,1,0,1. After the 4th grant releases, nBUSRQ goes high and the CPU regains the bus before the next episode starts.
- Request withdrawn in REQ_WAIT: req 1->0 before nBUSACK falls -> RELEASE, no gnt pulse ever, nBUSRQ back to 1.
- CPU never acks (nBUSACK stuck high) with ACK_TIMEOUT=16 -> ack_timeout=1 at cycle 17 after nBUSRQ falls, stays 1; gnt stays 0.
- RESET asserted mid-GRANT -> nBUSRQ=1, gnt=0, bus_oe=0, ack_timeout=0 within the same cycle. After release, the arbiter restarts cleanly from IDLE with master 0 first.
